// File: rtl/osc_measure_sequencer.sv
// -----------------------------------------------------------------------------
// osc_measure_sequencer
//
// Time-shares one saturating edge counter between two ring-oscillator outputs.
// For each oscillator in turn (A, then B) the block enables it, waits a settle
// interval, then counts its rising edges over a fixed gate window. The A count
// is parked in a holding register while B is measured. Both counts are then
// published together with a one-cycle valid pulse.
//
// Optional feature: define OSC_DIFF_EN to add the signed `diff` output
// (cnt_a - cnt_b, CNT_W+1 bits, registered alongside cnt_a/cnt_b).
//
// Ports:
//   clk, rst      sole clock; synchronous active-high reset
//   start         begin one A/B pair (sampled only in IDLE)
//   cont          continuous mode: restart after each pair
//   osc_a, osc_b  divided oscillator outputs (asynchronous to clk)
//   osc_en[1:0]   oscillator enables, bit0 = A, bit1 = B
//   sel           channel routed to the counter, 0 = A, 1 = B
//   busy          high in every state except IDLE
//   cnt_a, cnt_b  last completed counts
//   valid         one-cycle pulse when cnt_a/cnt_b update
//   diff          signed cnt_a - cnt_b (OSC_DIFF_EN only)
//   ovf           sticky counter-saturation flag, cleared only by rst
//
// Handshake: there is no back-pressure. `start` is a request seen only in
// IDLE; `valid` is a pure one-cycle strobe and the counts hold until the
// next strobe.
// -----------------------------------------------------------------------------
module osc_measure_sequencer #(
    parameter int CNT_W         = 16,
    parameter int GATE_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             osc_a,
    input  logic             osc_b,
    output logic [1:0]       osc_en,
    output logic             sel,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic             valid,
`ifdef OSC_DIFF_EN
    output logic signed [CNT_W:0] diff,
`endif
    output logic             ovf
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE_A = 3'd1,
        GATE_A   = 3'd2,
        SETTLE_B = 3'd3,
        GATE_B   = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t           state;
    state_t           state_nxt;
    logic [TW-1:0]    timer;
    logic [1:0]       sync_a;
    logic [1:0]       sync_b;
    logic             prev_a;
    logic             prev_b;
    logic             rise_a;
    logic             rise_b;
    logic             edge_sel;
    logic             gating;
    logic             sat;
    logic             settle_done;
    logic             gate_done;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_upd;
    logic [CNT_W-1:0] hold_a;

    // Rising edge: synchronized value is 1 and the value one cycle older was 0.
    assign rise_a = sync_a[1] & ~prev_a;
    assign rise_b = sync_b[1] & ~prev_b;

    // sel is registered from the next state, so it already matches the
    // channel of the current gate state.
    assign edge_sel    = sel ? rise_b : rise_a;
    assign gating      = (state == GATE_A) || (state == GATE_B);
    assign sat         = &cnt;
    assign settle_done = (timer == TW'(SETTLE_CYCLES - 1));
    assign gate_done   = (timer == TW'(GATE_CYCLES - 1));

    // Saturating increment; includes an edge detected in the current cycle so
    // the last gate cycle is counted when the A result is latched.
    assign cnt_upd = (gating && edge_sel && !sat) ? cnt + CNT_W'(1) : cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = SETTLE_A;
            SETTLE_A: if (settle_done) state_nxt = GATE_A;
            GATE_A:   if (gate_done) state_nxt = SETTLE_B;
            SETTLE_B: if (settle_done) state_nxt = GATE_B;
            GATE_B:   if (gate_done) state_nxt = DONE;
            DONE:     state_nxt = cont ? SETTLE_A : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            timer  <= '0;
            sync_a <= '0;
            sync_b <= '0;
            prev_a <= 1'b0;
            prev_b <= 1'b0;
            cnt    <= '0;
            hold_a <= '0;
            osc_en <= 2'b00;
            sel    <= 1'b0;
            busy   <= 1'b0;
            cnt_a  <= '0;
            cnt_b  <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
`ifdef OSC_DIFF_EN
            diff   <= '0;
`endif
        end else begin
            state <= state_nxt;

            // Timer restarts on every state change and idles at zero.
            if ((state_nxt != state) || (state == IDLE)) timer <= '0;
            else                                        timer <= timer + TW'(1);

            sync_a <= {sync_a[0], osc_a};
            sync_b <= {sync_b[0], osc_b};
            prev_a <= sync_a[1];
            prev_b <= sync_b[1];

            // Outputs are decoded from the next state so they are registered
            // yet line up with the state they describe.
            case (state_nxt)
                SETTLE_A, GATE_A: osc_en <= 2'b01;
                SETTLE_B, GATE_B: osc_en <= 2'b10;
                default:          osc_en <= 2'b00;
            endcase
            sel  <= (state_nxt == SETTLE_B) || (state_nxt == GATE_B);
            busy <= (state_nxt != IDLE);

            if ((state == SETTLE_A) || (state == SETTLE_B)) cnt <= '0;
            else                                            cnt <= cnt_upd;

            if (gating && edge_sel && sat) ovf <= 1'b1;

            if ((state == GATE_A) && gate_done) hold_a <= cnt_upd;

            valid <= (state == DONE);
            if (state == DONE) begin
                cnt_a <= hold_a;
                cnt_b <= cnt;
`ifdef OSC_DIFF_EN
                diff  <= $signed({1'b0, hold_a}) - $signed({1'b0, cnt});
`endif
            end
        end
    end

endmodule

// File: tb/tb_osc_measure_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for osc_measure_sequencer. Two instances share every input: one with
// CNT_W=16 and one with CNT_W=4 so saturation is reachable inside a short gate.
// Oscillators are driven on the falling clock edge from simple waveform
// descriptions; every driven value is logged per cycle, and expected counts
// are derived from that log: a rise seen in cycle n is detected in cycle n+2
// and is counted when that cycle lies inside the gate window.
// -----------------------------------------------------------------------------
module tb_osc_measure_sequencer;

    localparam int S    = 4;
    localparam int G    = 100;
    localparam int PAIR = 2 * (S + G) + 1;   // DONE offset from the start cycle
    localparam int HN   = 16384;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b1;
    logic start = 1'b0;
    logic cont  = 1'b0;
    logic osc_a = 1'b0;
    logic osc_b = 1'b0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic [1:0]  osc_en16, osc_en4;
    logic        sel16, sel4, busy16, busy4, valid16, valid4, ovf16, ovf4;
    logic [15:0] cnt_a16, cnt_b16;
    logic [3:0]  cnt_a4, cnt_b4;
`ifdef OSC_DIFF_EN
    logic signed [16:0] diff16;
    logic signed [4:0]  diff4;
`endif

    osc_measure_sequencer #(.CNT_W(16), .GATE_CYCLES(G), .SETTLE_CYCLES(S)) dut16 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .osc_a(osc_a), .osc_b(osc_b),
        .osc_en(osc_en16), .sel(sel16), .busy(busy16), .cnt_a(cnt_a16), .cnt_b(cnt_b16),
        .valid(valid16),
`ifdef OSC_DIFF_EN
        .diff(diff16),
`endif
        .ovf(ovf16));

    osc_measure_sequencer #(.CNT_W(4), .GATE_CYCLES(G), .SETTLE_CYCLES(S)) dut4 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .osc_a(osc_a), .osc_b(osc_b),
        .osc_en(osc_en4), .sel(sel4), .busy(busy4), .cnt_a(cnt_a4), .cnt_b(cnt_b4),
        .valid(valid4),
`ifdef OSC_DIFF_EN
        .diff(diff4),
`endif
        .ovf(ovf4));

    // ---------------- oscillator waveforms ----------------
    // mode 0: const 0, 1: const 1, 2: periodic (per, hi, phase), 3: single pulse
    int mode_a = 0, per_a = 4, hi_a = 2, ph_a = 0;
    int mode_b = 0, per_b = 4, hi_b = 2, ph_b = 0;
    logic hist_a [0:HN-1];
    logic hist_b [0:HN-1];

    function automatic logic osc_val(input int mode, input int per, input int hi,
                                     input int ph, input int c);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((c + ph) % per) < hi;
            default: return (c >= ph) && (c < ph + hi);
        endcase
    endfunction

    always @(negedge clk) begin
        osc_a = osc_val(mode_a, per_a, hi_a, ph_a, cyc);
        osc_b = osc_val(mode_b, per_b, hi_b, ph_b, cyc);
        if (cyc < HN) begin
            hist_a[cyc] = osc_a;
            hist_b[cyc] = osc_b;
        end
    end

    // Rises whose detection cycle (rise cycle + 2) falls in [gs, gs+G-1].
    function automatic int raw_count(input bit chan, input int gs);
        int n_rise = 0;
        for (int n = gs - 2; n <= gs + G - 3; n++) begin
            if (chan == 1'b0) begin
                if (hist_a[n] && !hist_a[n-1]) n_rise++;
            end else begin
                if (hist_b[n] && !hist_b[n-1]) n_rise++;
            end
        end
        return n_rise;
    endfunction

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [15:0] e_a16 = '0, e_b16 = '0;
    logic [3:0]  e_a4 = '0, e_b4 = '0;
    bit m_ovf16 = 1'b0, m_ovf4 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rand_osc;
        mode_a = $urandom_range(0, 3);
        per_a  = $urandom_range(3, 12);
        hi_a   = $urandom_range(1, per_a - 1);
        ph_a   = (mode_a == 3) ? cyc + $urandom_range(0, 150) : $urandom_range(0, per_a - 1);
        mode_b = $urandom_range(0, 3);
        per_b  = $urandom_range(3, 12);
        hi_b   = $urandom_range(1, per_b - 1);
        ph_b   = (mode_b == 3) ? cyc + $urandom_range(0, 150) : $urandom_range(0, per_b - 1);
    endtask

    task automatic check_results(input bit exp_busy);
        chk("valid16", 32'(valid16), 32'd1);
        chk("valid4", 32'(valid4), 32'd1);
        chk("cnt_a16", 32'(cnt_a16), 32'(e_a16));
        chk("cnt_b16", 32'(cnt_b16), 32'(e_b16));
        chk("cnt_a4", 32'(cnt_a4), 32'(e_a4));
        chk("cnt_b4", 32'(cnt_b4), 32'(e_b4));
        chk("ovf16", 32'(ovf16), 32'(m_ovf16));
        chk("ovf4", 32'(ovf4), 32'(m_ovf4));
        chk("busy_after_done", 32'(busy16), 32'(exp_busy));
`ifdef OSC_DIFF_EN
        begin
            logic [16:0] ed16;
            logic [4:0]  ed4;
            ed16 = {1'b0, e_a16} - {1'b0, e_b16};
            ed4  = {1'b0, e_a4} - {1'b0, e_b4};
            chk("diff16", 32'(diff16) & 32'h1ffff, 32'(ed16));
            chk("diff4", 32'(diff4) & 32'h1f, 32'(ed4));
        end
`endif
    endtask

    // Follows one pair whose start (or preceding DONE) is in cycle t.
    // pulse_off: offset at which a stray start is driven (0 = none).
    // drop_off : offset at which cont is dropped (0 = none).
    task automatic check_pair(input int t, input int pulse_off, input int drop_off);
        int o;
        int ra, rb;
        bit cont_done;
        cont_done = cont;
        while (cyc < t + PAIR + 1) begin
            tick();
            o = cyc - t;
            if (o >= 1 && o <= PAIR) chk("busy", 32'(busy16), 32'd1);
            if (o >= 1 && o <= S + G) begin
                chk("osc_en_a", 32'(osc_en16), 32'd1);
                chk("sel_a", 32'(sel16), 32'd0);
            end else if (o > S + G && o <= 2 * (S + G)) begin
                chk("osc_en_b", 32'(osc_en16), 32'd2);
                chk("sel_b", 32'(sel16), 32'd1);
            end
            if (o >= 2 && o <= PAIR) begin
                chk("valid16_low", 32'(valid16), 32'd0);
                chk("valid4_low", 32'(valid4), 32'd0);
            end
            start = (o == pulse_off);
            if (o == drop_off) cont = 1'b0;
            if (o == PAIR) cont_done = cont;
        end
        start = 1'b0;
        ra = raw_count(1'b0, t + S + 1);
        rb = raw_count(1'b1, t + 2 * S + G + 1);
        e_a16 = (ra > 65535) ? 16'hffff : 16'(ra);
        e_b16 = (rb > 65535) ? 16'hffff : 16'(rb);
        e_a4  = (ra > 15) ? 4'hf : 4'(ra);
        e_b4  = (rb > 15) ? 4'hf : 4'(rb);
        if (ra > 65535 || rb > 65535) m_ovf16 = 1'b1;
        if (ra > 15 || rb > 15) m_ovf4 = 1'b1;
        check_results(cont_done);
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_valid", 32'(valid16 | valid4), 32'd0);
            chk("idle_busy", 32'(busy16), 32'd0);
            chk("idle_osc_en", 32'(osc_en16), 32'd0);
            chk("idle_sel", 32'(sel16), 32'd0);
            chk("hold_cnt_a", 32'(cnt_a16), 32'(e_a16));
            chk("hold_cnt_b", 32'(cnt_b16), 32'(e_b16));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(valid16 | valid4), 32'd0);
        chk({tag, "_busy"}, 32'(busy16 | busy4), 32'd0);
        chk({tag, "_osc_en"}, 32'(osc_en16 | osc_en4), 32'd0);
        chk({tag, "_sel"}, 32'(sel16 | sel4), 32'd0);
        chk({tag, "_cnt16"}, 32'(cnt_a16 | cnt_b16), 32'd0);
        chk({tag, "_cnt4"}, 32'(cnt_a4 | cnt_b4), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf16 | ovf4), 32'd0);
`ifdef OSC_DIFF_EN
        chk({tag, "_diff"}, 32'(diff16) | 32'(diff4), 32'd0);
`endif
    endtask

    // ---------------- directed sequence ----------------
    int t;

    initial begin
        // reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_zero("reset");

        // A period 4, B period 5, random phases
        mode_a = 2; per_a = 4; hi_a = 2; ph_a = $urandom_range(0, 3);
        mode_b = 2; per_b = 5; hi_b = 2; ph_b = $urandom_range(0, 4);
        idle_check(4);
        start = 1'b1; t = cyc;
        check_pair(t, 0, 0);
        chk("cnt_a_near_25", 32'(cnt_a16 >= 16'd24 && cnt_a16 <= 16'd26), 32'd1);
        chk("cnt_b_near_20", 32'(cnt_b16 >= 16'd19 && cnt_b16 <= 16'd21), 32'd1);
        idle_check(5);

        // stray start during GATE_A is ignored: one valid, then idle
        set_rand_osc();
        start = 1'b1; t = cyc;
        check_pair(t, S + 10, 0);
        idle_check(20);

        // randomized pairs
        for (int k = 0; k < 4; k++) begin
            set_rand_osc();
            start = 1'b1; t = cyc;
            check_pair(t, 0, 0);
            idle_check(3);
        end

        // reset mid-GATE_B discards the pair
        mode_a = 2; per_a = 3; hi_a = 1;
        start = 1'b1; t = cyc;
        while (cyc < t + 2 * S + G + G / 2) begin
            tick();
            start = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e_a16 = '0; e_b16 = '0; e_a4 = '0; e_b4 = '0;
        m_ovf16 = 1'b0; m_ovf4 = 1'b0;
        check_zero("mid_rst");
        idle_check(PAIR + 2);

        // clean pair after reset (slow oscillators, no saturation)
        mode_a = 2; per_a = 20; hi_a = 10; ph_a = $urandom_range(0, 19);
        mode_b = 2; per_b = 12; hi_b = 5;  ph_b = $urandom_range(0, 11);
        start = 1'b1; t = cyc;
        check_pair(t, 0, 0);
        idle_check(2);

        // saturation on the 4-bit instance, then sticky through a clean pair
        mode_a = 2; per_a = 3; hi_a = 1; ph_a = 0;
        mode_b = 2; per_b = 7; hi_b = 3; ph_b = 2;
        start = 1'b1; t = cyc;
        check_pair(t, 0, 0);
        chk("cnt_a4_sat", 32'(cnt_a4), 32'd15);
        chk("ovf4_set", 32'(ovf4), 32'd1);
        mode_a = 1; mode_b = 0;
        idle_check(2);
        start = 1'b1; t = cyc;
        check_pair(t, 0, 0);
        chk("ovf4_sticky", 32'(ovf4), 32'd1);
        idle_check(2);

        // single edge inside SETTLE_A only, B held high: both counts 0
        mode_a = 3; hi_a = 2; ph_a = cyc + 1;
        mode_b = 1;
        start = 1'b1; t = cyc;
        check_pair(t, 0, 0);
        chk("settle_edge_ignored", 32'(cnt_a16), 32'd0);
        idle_check(2);

        // continuous mode with constant oscillators; drop cont mid-GATE_A
        mode_a = 0; mode_b = 1;
        cont = 1'b1;
        start = 1'b1; t = cyc;
        check_pair(t, 0, 0);
        t = t + PAIR;
        check_pair(t, 0, 0);
        t = t + PAIR;
        check_pair(t, 0, S + 20);
        idle_check(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/osc_measure_sequencer.md
# osc_measure_sequencer

Measurement controller for the dual on-chip ring-oscillator macro. It time-shares a single gated edge-counter between the two oscillator outputs. For each oscillator in turn it enables that oscillator, waits out a settle interval, then counts its rising edges over a fixed gate window of `clk` cycles. It publishes both counts as one result pair. The block sits between the oscillator macros (via their on-chip divided outputs) and the digital readout logic driving `uo_out`/`uio_out`.

## Interface

Parameters:
- `CNT_W`, 16: width of each count result.
- `GATE_CYCLES`, 1000: gate window length in `clk` cycles; ≥1.
- `SETTLE_CYCLES`, 4: settle interval per oscillator in `clk` cycles; ≥3 so the synchronizer pipeline flushes.

Ports:
- `clk`  in  1  system clock; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin one A/B measurement pair; sampled only in IDLE.
- `cont`  in  1  continuous mode: restart automatically after each pair.
- `osc_a`  in  1  divided oscillator A output; asynchronous to `clk`; frequency < f_clk/2.
- `osc_b`  in  1  divided oscillator B output; same constraints as `osc_a`.
- `osc_en`  out  2  oscillator enables; bit0 = A, bit1 = B.
- `sel`  out  1  oscillator currently routed to the counter; 0 = A, 1 = B.
- `busy`  out  1  high in every state except IDLE.
- `cnt_a`  out  CNT_W  last completed count for A.
- `cnt_b`  out  CNT_W  last completed count for B.
- `valid`  out  1  one-cycle pulse when `cnt_a`/`cnt_b` update.
- `ovf`  out  1  sticky; set when either counter saturates; cleared only by `rst`.
- `diff`  out  CNT_W+1  signed `cnt_a - cnt_b`; present only with `OSC_DIFF_EN`.

## Operation

- Each oscillator input passes through its own 2-flop synchronizer followed by an edge register. A rising edge is detected when the current synchronized value is 1 and the previous value was 0.
- Shared counter input mux is controlled by `sel`. Only the selected channel's detected edges increment the counter.
- FSM states: IDLE, SETTLE_A, GATE_A, SETTLE_B, GATE_B, DONE.
  - IDLE: `osc_en`=00, `sel`=0. If `start`=1, go to SETTLE_A.
  - SETTLE_A: `osc_en`=01, `sel`=0, counter cleared. Stay SETTLE_CYCLES cycles, then go to GATE_A.
  - GATE_A: `osc_en`=01. Count detected edges for exactly GATE_CYCLES cycles. On exit, latch the count into an internal A holding register, then go to SETTLE_B.
  - SETTLE_B / GATE_B: same as the A states, with `osc_en`=10 and `sel`=1. After GATE_B, go to DONE.
  - DONE: copy the A holding register to `cnt_a` and the B counter to `cnt_b`; `valid`=1. Next state is SETTLE_A if `cont`=1, else IDLE.
- Counter saturates at 2^CNT_W−1. An edge arriving at saturation sets `ovf`; the count holds.
- `start` outside IDLE is ignored; no queuing.
- Deasserting `cont` mid-pair: the current pair completes, then the FSM returns to IDLE.
- `rst` in any state: next cycle is IDLE. All outputs are 0, including `cnt_a`, `cnt_b`, `diff`, `ovf`, `valid`, `osc_en`, and `busy`. Synchronizers and counter are cleared. A partially measured pair is discarded.
- `cnt_a`/`cnt_b` hold their values between `valid` pulses.

## Timing

- Input synchronization latency is 2 cycles, plus 1 cycle for edge detect. Edges are counted if detection occurs in a GATE cycle.
- `start` high in IDLE at cycle t:
  - SETTLE_A occupies cycles t+1 … t+S.
  - GATE_A occupies cycles t+S+1 … t+S+G.
  - B phases follow with the same lengths.
  - DONE occurs at cycle t+2(S+G)+1 (S=SETTLE_CYCLES, G=GATE_CYCLES).
- `valid`, `cnt_a`, `cnt_b` (and `diff`) are registered. They are visible in the cycle after DONE, at t+2(S+G)+2.
- In continuous mode, `valid` pulses repeat every 2(S+G)+1 cycles.
- `busy` rises at t+1 and falls in the cycle after DONE unless `cont`=1.

## Configuration

- `OSC_DIFF_EN` defined: adds the `diff` port. `diff` is registered together with `cnt_a`/`cnt_b` and equals the sign-extended `cnt_a - cnt_b` (CNT_W+1 bits, two's complement).
- `OSC_DIFF_EN` undefined: `diff` port and subtractor are absent; all other behaviour is identical.

## Test plan

- S=4, G=100, `osc_a` period 4 clk, `osc_b` period 5 clk; pulse `start` → single `valid` at t+210; `cnt_a`=25±1, `cnt_b`=20±1; `diff`=5±2 with `OSC_DIFF_EN`; `busy` low afterwards.
- CNT_W=4, G=100, `osc_a` period 2.5 clk → `cnt_a`=15, `ovf`=1 and stays 1 through a second clean pair; clears only on `rst`.
- `start` pulsed again during GATE_A → ignored; exactly one `valid`; `osc_en` sequence is 01 then 10 then 00.
- `rst` asserted for 1 cycle mid-GATE_B of a pair → next cycle IDLE with all outputs 0; no `valid` for the aborted pair; the following `start` produces correct counts.
- `cont`=1 with constant oscillators → `valid` every 209 cycles (S=4, G=100); `cont` dropped mid-GATE_A → that pair completes with one more `valid`, then IDLE.
- `osc_a` held constant at 1 or 0 → `cnt_a`=0; an edge arriving only during SETTLE_A is not counted.
